// File: rtl/lru_matrix_mset_pkg.sv
// Shared defaults for the multi-set LRU matrix victim selector.
// Optional feature macro: LRU_WAY_LOCK_EN (adds lock_mask_i and victim_none_o reporting).
package lru_matrix_mset_pkg;
  localparam int DEF_NUM_SET   = 16;
  localparam int DEF_SET_DEPTH = 4;
  localparam int DEF_NUM_WAY   = 4;
  localparam int DEF_WAY_DEPTH = 2;
endpackage

// File: rtl/lru_matrix_mset_if.sv
// Update/query/result bundle for lru_matrix_mset.
// Macro LRU_WAY_LOCK_EN adds the lock_mask_i signal.
interface lru_matrix_mset_if
  import lru_matrix_mset_pkg::*;
#(
  parameter int SET_DEPTH = DEF_SET_DEPTH,
  parameter int NUM_WAY   = DEF_NUM_WAY,
  parameter int WAY_DEPTH = DEF_WAY_DEPTH
);
  logic                 flush_i;
  logic                 update_entry_i;
  logic [SET_DEPTH-1:0] update_set_i;
  logic [WAY_DEPTH-1:0] update_index_i;
  logic                 query_valid_i;
  logic [SET_DEPTH-1:0] query_set_i;
  logic [NUM_WAY-1:0]   line_valid_i;
`ifdef LRU_WAY_LOCK_EN
  logic [NUM_WAY-1:0]   lock_mask_i;
`endif
  logic                 victim_valid_o;
  logic [WAY_DEPTH-1:0] lru_index_o;
  logic                 victim_invalid_o;
  logic                 victim_none_o;

  modport master (
    output flush_i, update_entry_i, update_set_i, update_index_i,
    output query_valid_i, query_set_i, line_valid_i,
`ifdef LRU_WAY_LOCK_EN
    output lock_mask_i,
`endif
    input  victim_valid_o, lru_index_o, victim_invalid_o, victim_none_o
  );

  modport slave (
    input  flush_i, update_entry_i, update_set_i, update_index_i,
    input  query_valid_i, query_set_i, line_valid_i,
`ifdef LRU_WAY_LOCK_EN
    input  lock_mask_i,
`endif
    output victim_valid_o, lru_index_o, victim_invalid_o, victim_none_o
  );
endinterface

// File: rtl/lru_matrix_mset_set.sv
// Building blocks: one set's LRU matrix (lru_matrix_set), a lowest-index
// fixed-priority arbiter (fixed_pri_arb) and a one-hot to binary encoder (one2bin).
module lru_matrix_set #(
  parameter int NUM_WAY   = 4,
  parameter int WAY_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic                              update_i,
  input  logic [WAY_DEPTH-1:0]              update_index_i,
  output logic [NUM_WAY-1:0][NUM_WAY-1:0]   matrix_o
);
  logic [NUM_WAY-1:0][NUM_WAY-1:0] mat_q, mat_d;

  // Next matrix: flush clears everything; an update sets the row, then clears the column.
  always_comb begin
    mat_d = mat_q;
    if (flush_i) begin
      mat_d = '0;
    end else if (update_i) begin
      for (int j = 0; j < NUM_WAY; j++) begin
        for (int k = 0; k < NUM_WAY; k++) begin
          if (k == int'(update_index_i))      mat_d[j][k] = 1'b0;
          else if (j == int'(update_index_i)) mat_d[j][k] = 1'b1;
        end
      end
    end
  end

  // Matrix storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mat_q <= '0;
    else        mat_q <= mat_d;
  end

  assign matrix_o = mat_q;
endmodule

module fixed_pri_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  // Isolate the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));
endmodule

module one2bin #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] bin_o
);
  // OR together the indices of all set bits (exactly one expected).
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) bin_o = bin_o | W'(i);
    end
  end
endmodule

// File: rtl/lru_matrix_mset.sv
// Multi-set matrix-LRU victim selector with one-cycle registered results.
// Macro LRU_WAY_LOCK_EN enables per-way locking via lock_mask_i and victim_none_o.
module lru_matrix_mset
  import lru_matrix_mset_pkg::*;
#(
  parameter int NUM_SET   = DEF_NUM_SET,
  parameter int SET_DEPTH = DEF_SET_DEPTH,
  parameter int NUM_WAY   = DEF_NUM_WAY,
  parameter int WAY_DEPTH = DEF_WAY_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  lru_matrix_mset_if.slave   bus
);
  logic [NUM_WAY-1:0][NUM_WAY-1:0] all_mat [NUM_SET];
  logic [NUM_WAY-1:0][NUM_WAY-1:0] q_mat;
  logic [NUM_WAY-1:0]              elig;
  logic [NUM_WAY-1:0]              inv_req, inv_gnt, lru_req, lru_gnt;
  logic [WAY_DEPTH-1:0]            inv_bin, lru_bin, idx_d, idx_q;
  logic                            inv_d, inv_q, valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SET; gi++) begin : g_set
      lru_matrix_set #(.NUM_WAY(NUM_WAY), .WAY_DEPTH(WAY_DEPTH)) u_set (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (bus.flush_i),
        .update_i       (bus.update_entry_i && (bus.update_set_i == SET_DEPTH'(gi))),
        .update_index_i (bus.update_index_i),
        .matrix_o       (all_mat[gi])
      );
    end
  endgenerate

  // Queries read registered matrix state, so same-cycle updates/flushes are not seen.
  assign q_mat = all_mat[bus.query_set_i];

`ifdef LRU_WAY_LOCK_EN
  assign elig = ~bus.lock_mask_i;
`else
  assign elig = '1;
`endif

  assign inv_req = elig & ~bus.line_valid_i;

  // A way is LRU among the eligible ways when it is more recent than none of them.
  generate
    for (gi = 0; gi < NUM_WAY; gi++) begin : g_lru
      assign lru_req[gi] = elig[gi] && ((q_mat[gi] & elig) == '0);
    end
  endgenerate

  fixed_pri_arb #(.N(NUM_WAY)) u_arb_inv (.req_i(inv_req), .gnt_o(inv_gnt));
  fixed_pri_arb #(.N(NUM_WAY)) u_arb_lru (.req_i(lru_req), .gnt_o(lru_gnt));
  one2bin #(.N(NUM_WAY), .W(WAY_DEPTH)) u_bin_inv (.onehot_i(inv_gnt), .bin_o(inv_bin));
  one2bin #(.N(NUM_WAY), .W(WAY_DEPTH)) u_bin_lru (.onehot_i(lru_gnt), .bin_o(lru_bin));

  // Empty ways take precedence over the LRU way; no eligible way yields index 0.
  assign inv_d = |inv_req;
  assign idx_d = inv_d ? inv_bin : lru_bin;

  // Result registers: the valid pulse tracks the query, payload holds between queries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      valid_q <= bus.query_valid_i;
      if (bus.query_valid_i) begin
        idx_q <= idx_d;
        inv_q <= inv_d;
      end
    end
  end

`ifdef LRU_WAY_LOCK_EN
  logic none_q;

  // No-eligible-way flag, held like the rest of the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 none_q <= 1'b0;
    else if (bus.query_valid_i) none_q <= ~|elig;
  end

  assign bus.victim_none_o = none_q;
`else
  assign bus.victim_none_o = 1'b0;
`endif

  assign bus.victim_valid_o   = valid_q;
  assign bus.lru_index_o      = idx_q;
  assign bus.victim_invalid_o = inv_q;
endmodule
